// File: rtl/vt52_key_encoder_if.sv
// Key-event and outbound-byte handshake bundle for the VT52 key encoder.
interface vt52_key_encoder_if;
  logic [7:0] key_data;
  logic [1:0] key_kind;
  logic       key_valid;
  logic       key_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;

  // master: keyboard scanner + UART side; slave: the encoder
  modport master (
    output key_data, key_kind, key_valid, tx_ready,
    input  key_ready, tx_data, tx_valid, busy
  );

  modport slave (
    input  key_data, key_kind, key_valid, tx_ready,
    output key_ready, tx_data, tx_valid, busy
  );
endinterface

// File: rtl/vt52_key_encoder.sv
// VT52 host-bound byte generator: queues key events and expands each into
// its VT52 byte sequence (plain byte, ESC+cursor letter, ESC / K identify).
module vt52_key_encoder #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic               clk,
  input logic               clr_n,
  vt52_key_encoder_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] KIND_PLAIN  = 2'd0;
  localparam logic [1:0] KIND_CURSOR = 2'd1;
  localparam logic [1:0] KIND_IDENT  = 2'd2;
  localparam logic [1:0] KIND_RSVD   = 2'd3;

  // Bn encodings double as the byte index within the current sequence
  localparam logic [1:0] S_B0   = 2'd0;
  localparam logic [1:0] S_B1   = 2'd1;
  localparam logic [1:0] S_B2   = 2'd2;
  localparam logic [1:0] S_IDLE = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] data;
  } key_evt_t;

  key_evt_t         mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  key_evt_t         head;

  logic [1:0] state_q,    state_d;
  logic [1:0] kind_q,     kind_d;
  logic [7:0] data_q,     data_d;
  logic [7:0] tx_data_q,  tx_data_d;
  logic       tx_valid_q, tx_valid_d;
  logic       take_head;

  function automatic logic [7:0] seq_byte(input logic [1:0] kind,
                                          input logic [7:0] data,
                                          input logic [1:0] idx);
    logic [7:0] b;
    b = 8'h00;
    case (kind)
      KIND_PLAIN:  b = data;
      KIND_CURSOR: b = (idx == 2'd0) ? 8'h1B : 8'(8'h41 + {6'b0, data[1:0]});
      KIND_IDENT: begin
        case (idx)
          2'd0:    b = 8'h1B;
          2'd1:    b = 8'h2F;
          default: b = 8'h4B;
        endcase
      end
      default:     b = 8'h00;
    endcase
    return b;
  endfunction

  function automatic logic seq_last(input logic [1:0] kind,
                                    input logic [1:0] idx);
    logic l;
    case (kind)
      KIND_PLAIN:  l = (idx == 2'd0);
      KIND_CURSOR: l = (idx == 2'd1);
      default:     l = (idx == 2'd2);
    endcase
    return l;
  endfunction

  assign fifo_full     = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty    = (count == '0);
  assign push          = bus.key_valid && !fifo_full;
  assign head          = mem[rd_ptr];

  assign bus.key_ready = !fifo_full;
  assign bus.busy      = !fifo_empty || (state_q != S_IDLE);
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_valid  = tx_valid_q;

  // Event storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= key_evt_t'({bus.key_kind, bus.key_data});
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= PTR_W'(wr_ptr + PTR_W'(1));
      if (pop)  rd_ptr <= PTR_W'(rd_ptr + PTR_W'(1));
      count <= CNT_W'(count + CNT_W'(push) - CNT_W'(pop));
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= S_IDLE;
      kind_q     <= KIND_PLAIN;
      data_q     <= 8'h00;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      data_q     <= data_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  // Sequencer: on the last-byte transfer the next head is taken in the same
  // edge so consecutive sequences stream without a bubble
  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    data_d     = data_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    pop        = 1'b0;
    take_head  = 1'b0;

    case (state_q)
      S_IDLE: begin
        take_head = !fifo_empty;
      end
      S_B0, S_B1, S_B2: begin
        if (bus.tx_ready) begin
          if (!seq_last(kind_q, state_q)) begin
            state_d   = 2'(state_q + 2'd1);
            tx_data_d = seq_byte(kind_q, data_q, 2'(state_q + 2'd1));
          end else if (!fifo_empty) begin
            take_head = 1'b1;
          end else begin
            state_d    = S_IDLE;
            tx_valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d    = S_IDLE;
        tx_valid_d = 1'b0;
      end
    endcase

    if (take_head) begin
      pop    = 1'b1;
      kind_d = head.kind;
      data_d = head.data;
      if (head.kind == KIND_RSVD) begin
        state_d    = S_IDLE;
        tx_valid_d = 1'b0;
      end else begin
        state_d    = S_B0;
        tx_valid_d = 1'b1;
        tx_data_d  = seq_byte(head.kind, head.data, 2'd0);
      end
    end
  end

endmodule

// File: tb/tb_vt52_key_encoder.sv
// Directed self-checking bench for vt52_key_encoder with hand-computed vectors.
module tb_vt52_key_encoder;

  logic clk;
  logic clr_n;
  int   n_assert;
  int   n_fail;
  int   accepted;

  vt52_key_encoder_if bus ();

  vt52_key_encoder #(.FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_evt(input logic [1:0] kind, input logic [7:0] data);
    bus.key_valid = 1'b1;
    bus.key_kind  = kind;
    bus.key_data  = data;
  endtask

  logic [7:0] exp_ci [5];

  initial begin
    n_assert = 0;
    n_fail   = 0;
    accepted = 0;
    exp_ci   = '{8'h1B, 8'h44, 8'h1B, 8'h2F, 8'h4B};

    clr_n         = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_kind  = 2'd0;
    bus.key_data  = 8'h00;
    bus.tx_ready  = 1'b0;
    tick();
    tick();
    chk("rst_tx_valid",  8'(bus.tx_valid),  8'h00);
    chk("rst_tx_data",   bus.tx_data,       8'h00);
    chk("rst_key_ready", 8'(bus.key_ready), 8'h01);
    chk("rst_busy",      8'(bus.busy),      8'h00);
    clr_n = 1'b1;
    tick();

    // plain byte: push at N, tx_valid after N+1 for one cycle
    bus.tx_ready = 1'b1;
    drive_evt(2'd0, 8'h61);
    tick();
    bus.key_valid = 1'b0;
    chk("plain_n_valid", 8'(bus.tx_valid), 8'h00);
    chk("plain_n_busy",  8'(bus.busy),     8'h01);
    tick();
    chk("plain_valid", 8'(bus.tx_valid), 8'h01);
    chk("plain_data",  bus.tx_data,      8'h61);
    tick();
    chk("plain_done_valid", 8'(bus.tx_valid), 8'h00);
    chk("plain_done_busy",  8'(bus.busy),     8'h00);

    // cursor left then identify, streamed with no bubble
    drive_evt(2'd1, 8'h03);
    tick();
    drive_evt(2'd2, 8'h00);
    tick();
    bus.key_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("ci_valid_%0d", i), 8'(bus.tx_valid), 8'h01);
      chk($sformatf("ci_data_%0d", i),  bus.tx_data,      exp_ci[i]);
      tick();
    end
    chk("ci_done_valid", 8'(bus.tx_valid), 8'h00);
    chk("ci_done_busy",  8'(bus.busy),     8'h00);

    // backpressure on a cursor-up sequence
    bus.tx_ready = 1'b0;
    drive_evt(2'd1, 8'h00);
    tick();
    bus.key_valid = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bp_valid_%0d", i), 8'(bus.tx_valid), 8'h01);
      chk($sformatf("bp_data_%0d", i),  bus.tx_data,      8'h1B);
      tick();
    end
    bus.tx_ready = 1'b1;
    tick();
    chk("bp_second_valid", 8'(bus.tx_valid), 8'h01);
    chk("bp_second_data",  bus.tx_data,      8'h41);
    tick();
    chk("bp_done_valid", 8'(bus.tx_valid), 8'h00);

    // full FIFO: 4 entries plus one held by the sequencer
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive_evt(2'd0, 8'(8'h30 + i));
      if (bus.key_ready) accepted++;
      tick();
    end
    bus.key_valid = 1'b0;
    chk("full_accepted",  8'(accepted),      8'h05);
    chk("full_key_ready", 8'(bus.key_ready), 8'h00);
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("full_valid_%0d", i), 8'(bus.tx_valid), 8'h01);
      chk($sformatf("full_data_%0d", i),  bus.tx_data,      8'(8'h30 + i));
      tick();
    end
    chk("full_done_valid",     8'(bus.tx_valid),  8'h00);
    chk("full_done_key_ready", 8'(bus.key_ready), 8'h01);
    chk("full_done_busy",      8'(bus.busy),      8'h00);

    // reserved kind is dropped, following plain byte still appears
    drive_evt(2'd3, 8'hFF);
    tick();
    drive_evt(2'd0, 8'h42);
    tick();
    bus.key_valid = 1'b0;
    chk("rsvd_skip_valid", 8'(bus.tx_valid), 8'h00);
    tick();
    chk("rsvd_next_valid", 8'(bus.tx_valid), 8'h01);
    chk("rsvd_next_data",  bus.tx_data,      8'h42);
    tick();
    chk("rsvd_done_valid", 8'(bus.tx_valid), 8'h00);
    chk("rsvd_done_busy",  8'(bus.busy),     8'h00);

    // reset mid-sequence aborts and nothing resumes afterwards
    bus.tx_ready = 1'b0;
    drive_evt(2'd2, 8'h00);
    tick();
    drive_evt(2'd0, 8'h55);
    tick();
    bus.key_valid = 1'b0;
    bus.tx_ready  = 1'b1;
    tick();
    chk("mid_data", bus.tx_data, 8'h2F);
    bus.tx_ready = 1'b0;
    clr_n = 1'b0;
    #1;
    chk("mid_rst_tx_valid",  8'(bus.tx_valid),  8'h00);
    chk("mid_rst_tx_data",   bus.tx_data,       8'h00);
    chk("mid_rst_key_ready", 8'(bus.key_ready), 8'h01);
    chk("mid_rst_busy",      8'(bus.busy),      8'h00);
    tick();
    chk("hold_rst_key_ready", 8'(bus.key_ready), 8'h01);
    clr_n        = 1'b1;
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("post_rst_valid_%0d", i), 8'(bus.tx_valid), 8'h00);
    end
    chk("post_rst_busy", 8'(bus.busy), 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/vt52_key_encoder.md
# vt52_key_encoder

Host-bound byte generator for the VT52 terminal, sitting between the keyboard scanner and the UART transmitter. It is the outbound counterpart of the inbound command handler. It accepts key events and reply requests into a small FIFO, expands each event into the VT52 byte sequence (plain byte, ESC+cursor letter, or ESC / K identify reply), and streams the bytes out over a valid/ready handshake.

## Interface
Parameters:
- FIFO_DEPTH, default 4, number of key-event entries. Must be a power of two, 2 or more.

Ports:
- clk  in  1  system clock. Single clock domain.
- clr_n  in  1  asynchronous, active-low reset.
- key_data  in  8  event payload.
- key_kind  in  2  event kind:
  - 0 = plain byte
  - 1 = cursor key
  - 2 = identify reply
  - 3 = reserved
- key_valid  in  1  event offered.
- key_ready  out  1  FIFO not full. An event is accepted on a clk edge where key_valid && key_ready.
- tx_data  out  8  outbound byte.
- tx_valid  out  1  tx_data holds a byte.
- tx_ready  in  1  transmitter accepts the byte. A byte transfers on a clk edge where tx_valid && tx_ready.
- busy  out  1  FIFO non-empty or sequence in progress.

## Operation
- FIFO: FIFO_DEPTH entries of {kind[1:0], data[7:0]}.
  - Write and read pointers have width log2(FIFO_DEPTH) and wrap modulo FIFO_DEPTH.
  - Count width is log2(FIFO_DEPTH)+1.
  - key_ready = (count != FIFO_DEPTH), computed from the registered count only.
  - A push presented while full is not accepted, even if a pop occurs on the same edge.
  - Simultaneous push and pop leaves count unchanged.
- Expansion of each event kind:
  - Kind 0: 1 byte, key_data unchanged (any value 0x00..0xFF).
  - Kind 1: 2 bytes, 0x1B then a letter selected by data[1:0]:
    - 0 = 'A' 0x41 (up)
    - 1 = 'B' 0x42 (down)
    - 2 = 'C' 0x43 (right)
    - 3 = 'D' 0x44 (left)
    - data[7:2] is ignored.
  - Kind 2: 3 bytes, 0x1B, 0x2F, 0x4B.
  - Kind 3: popped and discarded. No bytes are emitted.
- Sequencer states:
  - IDLE: tx_valid=0. If the FIFO is non-empty, pop the head and latch kind/data. Kind 0/1/2 loads the first byte, asserts tx_valid, and moves to B0. Kind 3 stays in IDLE.
  - B0, B1, B2 (byte index 0..2 of the current sequence): tx_data and tx_valid are held while tx_ready=0. On transfer:
    - If more bytes remain, load the next byte and go to the next Bn.
    - If this was the last byte and the FIFO is non-empty, pop the head and load its first byte in the same edge, with no bubble. A kind-3 head popped here returns to IDLE with tx_valid=0.
    - If this was the last byte and the FIFO is empty, go to IDLE with tx_valid=0.
- tx_data is stable and tx_valid never drops between assertion and transfer.
- busy = (count != 0) || (state != IDLE).
- Reset (clr_n low, any time, including mid-sequence):
  - FIFO emptied, state IDLE.
  - tx_valid=0, tx_data=0x00, busy=0, key_ready=1. key_ready=1 holds while clr_n is low.
  - Partial sequences are aborted and not resumed.

## Timing
- Push at edge N sets count=1 after N. The pop happens at edge N+1, so tx_valid=1 after N+1. First-byte latency is 2 edges from acceptance when idle; there is no bypass.
- Bytes within a sequence transfer back-to-back: with tx_ready=1, one byte per clk.
- Consecutive sequences also transfer back-to-back when the next entry is present in the FIFO before the last-byte edge.
- Total storage is FIFO_DEPTH entries plus one entry held by the sequencer. With tx_ready=0 from idle, FIFO_DEPTH+1 events are accepted before key_ready drops.
- key_ready rises one edge after the pop that frees an entry.
- All outputs are registered except key_ready and busy, which are decoded from registers.

## Test plan
- Reset: assert clr_n=0 mid-sequence -> tx_valid=0, tx_data=0x00, key_ready=1, busy=0. After release, no residual bytes are emitted.
- Plain byte: push kind 0 / 0x61 at edge N, tx_ready=1 -> tx_valid high after N+1 with tx_data=0x61 for exactly one cycle, then busy=0.
- Cursor and identify: push kind 1 / 0x03, then kind 2, tx_ready=1 -> stream 0x1B 0x44 0x1B 0x2F 0x4B on 5 consecutive edges with no bubble.
- Backpressure: kind 1 / 0x00 with tx_ready=0 for 10 cycles -> 0x1B held stable with tx_valid=1. After tx_ready=1 -> 0x1B then 0x41.
- Full FIFO (depth 4): tx_ready=0, offer 8 kind-0 events 0x30..0x37 -> exactly 5 accepted and key_ready=0. After tx_ready=1 -> 0x30..0x34 in order, and key_ready=1 again.
- Reserved kind: push kind 3 / 0xFF, then kind 0 / 0x42 -> only 0x42 appears on tx_data.
